// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single integer register-file write port between the in-order
// write-back stage and a late-completion source. Late results are queued in
// a small FIFO. Write-back normally has priority. A starvation counter
// forces the FIFO head through when it has been denied for too long. Late
// results are older in program order, so a write-back that targets a
// register still pending in the FIFO is held until the FIFO drains past it.

module regfile_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3,
  parameter int XLEN         = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_valid,
  input  logic [4:0]                wb_dest_reg,
  input  logic [XLEN-1:0]           wb_data,
  output logic                      wb_ready,
  input  logic                      late_valid,
  input  logic [4:0]                late_dest_reg,
  input  logic [XLEN-1:0]           late_data,
  output logic                      late_ready,
  output logic                      register_write_enable,
  output logic [4:0]                register_write_addr,
  output logic [XLEN-1:0]           register_write_data,
  output logic                      wb_done,
  output logic                      late_done,
  output logic [31:0]               pending_mask,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    PRIO_WB    = 1'b0,
    FORCE_LATE = 1'b1
  } arb_state_t;

  logic [4:0]          fifo_dest [DEPTH];
  logic [XLEN-1:0]     fifo_data [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count_q;
  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_next;
  arb_state_t          state;
  arb_state_t          state_next;

  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                conflict;
  logic                wb_win;
  logic                late_win;
  logic [4:0]          win_dest;
  logic [XLEN-1:0]     win_data;

  assign fifo_empty = (count_q == '0);
  assign late_ready = (count_q < CNT_W'(DEPTH));
  assign push       = late_valid && late_ready;
  assign fifo_count = count_q;

  // Pending mask: OR of the destinations of every occupied FIFO slot; x0 never pends
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] offset;
      offset = PTR_W'(i) - rd_ptr;
      if ({1'b0, offset} < count_q) begin
        pending_mask[fifo_dest[i]] = 1'b1;
      end
    end
    pending_mask[0] = 1'b0;
  end

  assign conflict = wb_valid && (wb_dest_reg != 5'd0) && pending_mask[wb_dest_reg];

  // Arbitration: pick this cycle's winner, track starvation, choose next state
  always_comb begin
    wb_win      = 1'b0;
    late_win    = 1'b0;
    state_next  = state;
    starve_next = starve_cnt;

    case (state)
      PRIO_WB: begin
        if (wb_valid && !conflict) begin
          wb_win = 1'b1;
        end else if (!fifo_empty) begin
          late_win = 1'b1;
        end
      end
      FORCE_LATE: begin
        if (!fifo_empty) begin
          late_win = 1'b1;
        end
      end
      default: begin
        wb_win   = 1'b0;
        late_win = 1'b0;
      end
    endcase

    if (fifo_empty || late_win) begin
      starve_next = '0;
    end else if (starve_cnt < STARVE_W'(STARVE_LIMIT)) begin
      starve_next = starve_cnt + STARVE_W'(1);
    end

    if (fifo_empty || late_win) begin
      state_next = PRIO_WB;
    end else if (starve_next >= STARVE_W'(STARVE_LIMIT)) begin
      state_next = FORCE_LATE;
    end
  end

  assign wb_ready = wb_win;
  assign pop      = late_win;
  assign win_dest = late_win ? fifo_dest[rd_ptr] : wb_dest_reg;
  assign win_data = late_win ? fifo_data[rd_ptr] : wb_data;

  // FIFO storage; contents need no reset because occupancy gates every use
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dest[wr_ptr] <= late_dest_reg;
      fifo_data[wr_ptr] <= late_data;
    end
  end

  // FIFO pointers, occupancy, starvation counter and arbiter state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      starve_cnt <= '0;
      state      <= PRIO_WB;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      starve_cnt <= starve_next;
      state      <= state_next;
    end
  end

  // Commit register: one write per cycle, x0 writes consumed with enable low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      register_write_enable <= 1'b0;
      register_write_addr   <= '0;
      register_write_data   <= '0;
      wb_done               <= 1'b0;
      late_done             <= 1'b0;
    end else begin
      wb_done   <= wb_win;
      late_done <= late_win;
      if (wb_win || late_win) begin
        if (win_dest != 5'd0) begin
          register_write_enable <= 1'b1;
          register_write_addr   <= win_dest;
          register_write_data   <= win_data;
        end else begin
          register_write_enable <= 1'b0;
          register_write_addr   <= '0;
          register_write_data   <= '0;
        end
      end else begin
        register_write_enable <= 1'b0;
      end
    end
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single integer register-file write port between two producers:
  - the in-order write-back stage (primary source);
  - a late-completion source for results that finish out of band, such as system-call returns or long-latency loads.
- Late results are buffered in a small FIFO.
- Arbitration is fixed-priority with an anti-starvation override.
- Provides a pending-destination mask that the hazard/stall logic uses to hold dependent instructions.

Parameters:
- DEPTH, 4, late-result FIFO entries; must be a power of 2, at least 2.
- STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO may be denied before it is forced to win.
- XLEN, 64, data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wb_valid  in  1  write-back stage presents a result.
- wb_dest_reg  in  5  destination register for wb.
- wb_data  in  XLEN  result data for wb.
- wb_ready  out  1  wb result accepted this cycle (combinational).
- late_valid  in  1  late source presents a result.
- late_dest_reg  in  5  destination register for late.
- late_data  in  XLEN  result data for late.
- late_ready  out  1  FIFO can accept (combinational).
- register_write_enable  out  1  registered write strobe to the register file.
- register_write_addr  out  5  registered write address.
- register_write_data  out  XLEN  registered write data.
- wb_done  out  1  registered 1-cycle pulse: wb result committed.
- late_done  out  1  registered 1-cycle pulse: FIFO entry committed.
- pending_mask  out  32  bit r set while any FIFO entry targets r; bit 0 is always 0.
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO is emptied; the starvation counter is cleared; arbiter state is PRIO_WB.
  - All registered outputs go to 0.
  - pending_mask=0 and fifo_count=0.
  - A reset mid-operation discards buffered entries; no done pulse is issued for them.
- FIFO push:
  - Condition: late_valid && late_ready.
  - late_ready = (fifo_count < DEPTH). A pop in the same cycle does not free space for a push in that cycle.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo DEPTH.
- Arbiter states:
  - PRIO_WB: wb wins if wb_valid and there is no conflict. Otherwise the FIFO head wins if the FIFO is non-empty.
  - FORCE_LATE: entered when starve_cnt reaches STARVE_LIMIT. The FIFO head wins unconditionally and wb_ready=0. Returns to PRIO_WB after that single pop.
- Starvation counter (starve_cnt):
  - Increments each cycle the FIFO is non-empty and not popped.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Ordering conflict:
  - Applies when wb_valid, wb_dest_reg != 0, and pending_mask[wb_dest_reg]=1. Late results are older in program order.
  - Response: wb_ready=0 and the FIFO is popped (drained) until the mask bit clears.
- wb_ready = wb_valid && state==PRIO_WB && !conflict.
  - wb_valid with an empty FIFO is always accepted in the same cycle.
- Commit:
  - The winning entry is registered on the next edge: register_write_addr/register_write_data take the winner's values, and wb_done or late_done pulses for 1 cycle. Latency is 1 cycle from acceptance or pop.
  - register_write_enable = 1 only when the winner's dest != 0.
  - A write to x0 is consumed and its done pulse still fires, but the enable stays 0 and addr/data are driven to 0.
- Idle cycle (no winner): register_write_enable=0, both done pulses 0; addr/data hold their previous values.
- pending_mask:
  - Recomputed from the valid FIFO entries each cycle, reflecting post-edge occupancy.
  - Duplicate destinations in the FIFO keep the bit set until the last matching entry pops.
- Only one write is issued per cycle; the two sources are never merged.

Test Plan:
- Reset, then wb_valid=1, dest=5, data=0xA5 with FIFO empty → wb_ready=1 same cycle; next cycle enable=1, addr=5, data=0xA5, wb_done=1.
- Push late dest=7 data=0x11 while wb busy with dest=3 for 5 cycles → FIFO denied for 3 cycles, then FORCE_LATE. Next cycle addr=7, late_done=1, wb_ready=0 during the forced cycle. Afterwards wb resumes.
- FIFO holds dest=9; wb_valid dest=9 → wb_ready=0, FIFO pops (addr=9 late write), pending_mask[9] clears. wb then accepted the following cycle; write order is late before wb.
- Fill FIFO with 4 entries → late_ready=0 and fifo_count=4. A 5th push plus a simultaneous pop: push refused, fifo_count=3. Wrap-around verified over 10 push/pop pairs, with data order preserved.
- wb dest=0 data=0xFF → wb_done=1, register_write_enable=0, addr=0, data=0.
- With 3 FIFO entries, assert reset low asynchronously mid-cycle → outputs immediately 0, fifo_count=0, pending_mask=0, no late_done after release.
